// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/hold control, optional auto-reload on
// expiry, and a one-cycle expired pulse for each 1->0 transition.
module countdown_timer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Priority per cycle: Reset > load > stop > start > tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count   <= ZERO;
            reload  <= ZERO;
            state   <= IDLE;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                count  <= load_value;
                reload <= load_value;
                state  <= IDLE;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= HOLD;
                end
            end else if (start) begin
                case (state)
                    IDLE, HOLD: begin
                        if (count != ZERO) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (reload != ZERO) begin
                            count <= reload;
                            state <= RUN;
                        end
                    end
                    default: ;
                endcase
            end else if (tick && (state == RUN)) begin
                if (count > ONE) begin
                    count <= count - ONE;
                end else if (count == ONE) begin
                    // auto_reload only matters on this expiring edge
                    expired <= 1'b1;
                    if (auto_reload && (reload != ZERO)) begin
                        count <= reload;
                    end else begin
                        count <= ZERO;
                        state <= DONE;
                    end
                end
            end
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
